mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the CPU's single byte-wide RAM port. It arbitrates between instruction fetch (IF, 4-byte reads only) and the MEM stage (1/2/4-byte loads and stores). The winning request is broken into consecutive byte accesses on the RAM port. Read bytes are reassembled little-endian and returned with a one-cycle done pulse. It sits between the IF/MEM stages and the RAM, so neither stage has to sequence bytes itself.

## Interface
- ADDR_W, 32, width of requester and RAM addresses
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  IF fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_flush  in  1  cancels an in-flight or pending IF fetch
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle
- if_data  out  32  fetched word, little-endian
- mem_req  in  1  MEM request, level, held until mem_done
- mem_rw  in  1  0 = load, 1 = store
- mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = treated as 4 bytes
- mem_addr  in  ADDR_W  base byte address
- mem_wdata  in  32  store data; byte k is bits [8k+7:8k]
- mem_done  out  1  one-cycle pulse; mem_rdata valid in the same cycle
- mem_rdata  out  32  load data, zero-extended raw bytes (the MEM stage does sign extension)
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  1 = write the ram_dout byte at ram_a
- ram_dout  out  8  write byte
- ram_din  in  8  read byte, valid one cycle after its address is driven
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states:
  - IDLE: arbitrates at each rising edge.
  - XFER: issues byte cnt = 0..N-1.
  - DRAIN: one cycle, reads only; captures the last byte.
  - DONE: one cycle; asserts the done pulse.
- Arbitration in IDLE: mem_req has fixed priority over if_req. if_req is ignored while if_flush is high. No preemption once a transfer is granted.
- On grant, latch: owner, rw, N (IF: 4; MEM: from mem_len), base address, write data. Set cnt = 0.
- XFER, per cycle:
  - ram_a = base + cnt, computed modulo 2^ADDR_W (address wrap permitted).
  - ram_wr = rw; ram_dout = wdata byte cnt.
  - cnt increments each cycle. After byte N-1: writes go to DONE, reads go to DRAIN.
- Read capture: at each edge after byte k is issued, ram_din is stored into data[8k+7:8k]. Unread upper bytes are 0.
- DONE: assert the owner's done pulse and data for one cycle, then go to IDLE. No arbitration happens on the DONE->IDLE edge.
  - A requester must drop req during its done cycle. A req still high in the following IDLE cycle starts a new transaction.
- if_flush while IF owns XFER/DRAIN:
  - The next edge goes to IDLE with no if_done.
  - ram_wr stays 0. Captured data is discarded.
- MEM transfers are never aborted. if_flush has no effect on them.
- Outputs while not in XFER: ram_wr = 0. ram_a and ram_dout hold their last value. Done pulses are 0 outside DONE.
- if_data and mem_rdata hold their value after done. Each is updated only by its own transaction.

## Timing
- All outputs are registered.
- Reset values: if_done = 0, mem_done = 0, if_data = 0, mem_rdata = 0, ram_a = 0, ram_wr = 0, ram_dout = 0, busy = 0, state = IDLE.
- Reset mid-transfer: outputs go to reset values immediately (asynchronous). The transaction is lost and no done pulse is issued. The requester must re-request.
- Grant edge E0. Byte k is on the RAM port during the cycle after E(k).
- Read latency:
  - Byte k is captured at E(k+1); the last capture is at E(N).
  - Done is high after E(N+1).
  - LW/fetch: done is 5 cycles after the grant edge. LB: 2 cycles.
- Write latency: the last byte is on the port after E(N-1); done is high after E(N). SB: 1 cycle. SW: 4 cycles.
- Throughput: one bubble cycle (DONE) plus one IDLE arbitration cycle between back-to-back transactions.
- busy is high from the cycle after E0 through the DONE cycle.

## Test plan
- IF fetch at if_addr = 0x100, RAM bytes 11,22,33,44 -> ram_a steps 0x100..0x103 with ram_wr = 0; if_done after E5 with if_data = 0x44332211.
- MEM SW at mem_addr = 0x200, mem_wdata = 0xDEADBEEF -> writes EF,BE,AD,DE to 0x200..0x203; mem_done after E4; no if_done.
- mem_req (LH at 0x10, bytes 0x80,0xFF) and if_req raised in the same cycle -> MEM granted first; mem_rdata = 0x0000FF80. IF is granted at the first arbitration after MEM's DONE.
- if_flush asserted during XFER cnt = 2 of a fetch -> next edge returns to IDLE; no if_done; a following MEM LB completes normally.
- LW at mem_addr = 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rst pulsed mid-SW -> all outputs 0 immediately; no mem_done; the next request sequences from cnt = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM port
// Ports: clk/rst (async, active-high); IF side if_req/if_addr/if_flush -> if_done/if_data;
// MEM side mem_req/mem_rw/mem_len/mem_addr/mem_wdata -> mem_done/mem_rdata;
// RAM side ram_a/ram_wr/ram_dout -> ram_din; busy is high whenever not idle.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic              own_mem, rw;
  logic [1:0]        cnt, last_idx;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata, data;
  logic              grant_mem, grant_if, grant, flush, last;
  logic              g_rw;
  logic [1:0]        g_last;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;
  always_comb begin
    grant_mem = state == IDLE && mem_req;
    grant_if  = state == IDLE && !mem_req && if_req && !if_flush;
    grant     = grant_mem || grant_if;
    flush     = !own_mem && if_flush && (state == XFER || state == DRAIN);
    last      = cnt == last_idx;
    g_rw      = grant_mem ? mem_rw : 1'b0;
    g_last    = !grant_mem ? 2'd3 : mem_len == 2'b00 ? 2'd0 : mem_len == 2'b01 ? 2'd1 : 2'd3;
    g_addr    = grant_mem ? mem_addr : if_addr;
    g_wdata   = grant_mem ? mem_wdata : 32'd0;
    state_nxt = flush ? IDLE :
                state == IDLE ? (grant ? XFER : IDLE) :
                state == XFER ? (last ? (rw ? DONE : DRAIN) : XFER) :
                state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_mem   <= 1'b0;
      rw        <= 1'b0;
      cnt       <= 2'd0;
      last_idx  <= 2'd0;
      base      <= '0;
      wdata     <= 32'd0;
      data      <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= 8'd0;
      busy      <= 1'b0;
    end else begin
      if_done  <= state_nxt == DONE && !own_mem;
      mem_done <= state_nxt == DONE && own_mem;
      busy     <= state_nxt != IDLE;
      ram_wr   <= 1'b0;
      if (grant) begin
        own_mem  <= grant_mem;
        rw       <= g_rw;
        last_idx <= g_last;
        base     <= g_addr;
        wdata    <= g_wdata;
        cnt      <= 2'd0;
        data     <= 32'd0;
        ram_a    <= g_addr;
        ram_wr   <= g_rw;
        ram_dout <= g_wdata[7:0];
      end else if (state == XFER) begin
        if (!rw) data[{cnt, 3'b000} +: 8] <= ram_din;
        if (!last) begin
          cnt      <= cnt + 2'd1;
          ram_a    <= base + ADDR_W'(cnt + 2'd1);
          ram_wr   <= rw;
          ram_dout <= wdata[{cnt + 2'd1, 3'b000} +: 8];
        end
      end
      // Read data is published only on the DRAIN->DONE edge, so a flushed fetch never reaches if_data.
      if (state == DRAIN && !flush) begin
        if (own_mem) mem_rdata <= data;
        else if_data <= data;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_rw = 1'b0;
  logic [31:0] if_addr = 32'd0, mem_addr = 32'd0, mem_wdata = 32'd0;
  logic [1:0]  mem_len = 2'd0;
  logic        if_done, mem_done, ram_wr, busy;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic [7:0]  ram [256];
  logic [7:0]  wmem [256];
  int          n_chk = 0, n_fail = 0;
  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din), .busy(busy)
  );
  always #5 clk = ~clk;
  assign ram_din = ram[ram_a[7:0]];
  always @(posedge clk) if (ram_wr) wmem[ram_a[7:0]] = ram_dout;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      wmem[i] = 8'h00;
    end
    #2;
    check("rst_busy", busy, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_if_done", if_done, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_data", if_data, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    tick();
    rst = 1'b0;
    // IF fetch at 0x100
    ram[8'h00] = 8'h11; ram[8'h01] = 8'h22; ram[8'h02] = 8'h33; ram[8'h03] = 8'h44;
    if_addr = 32'h100;
    if_req = 1'b1;
    tick();
    check("f_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      check("f_ram_a", ram_a, 32'h100 + k);
      check("f_ram_wr", ram_wr, 0);
      if (k < 3) tick();
    end
    tick();
    check("f_drain_done", if_done, 0);
    tick();
    check("f_if_done", if_done, 1);
    check("f_if_data", if_data, 32'h44332211);
    check("f_no_mem_done", mem_done, 0);
    if_req = 1'b0;
    tick();
    check("f_done_drop", if_done, 0);
    check("f_idle", busy, 0);
    check("f_hold", if_data, 32'h44332211);
    // MEM SW at 0x200
    mem_addr = 32'h200; mem_rw = 1'b1; mem_len = 2'b10; mem_wdata = 32'hDEADBEEF;
    mem_req = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("sw_ram_a", ram_a, 32'h200 + k);
      check("sw_ram_wr", ram_wr, 1);
      check("sw_mem_done_low", mem_done, 0);
      tick();
    end
    check("sw_mem_done", mem_done, 1);
    check("sw_if_done", if_done, 0);
    check("sw_ram_wr_off", ram_wr, 0);
    check("sw_ram_a_hold", ram_a, 32'h203);
    check("sw_rdata_untouched", mem_rdata, 0);
    check("sw_bytes", {wmem[3], wmem[2], wmem[1], wmem[0]}, 32'hDEADBEEF);
    mem_req = 1'b0;
    tick();
    // LH and IF raised together: MEM wins
    ram[8'h10] = 8'h80; ram[8'h11] = 8'hFF;
    ram[8'h00] = 8'hEF; ram[8'h01] = 8'hBE; ram[8'h02] = 8'hAD; ram[8'h03] = 8'hDE;
    mem_addr = 32'h10; mem_rw = 1'b0; mem_len = 2'b01; mem_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    check("lh_win_a0", ram_a, 32'h10);
    tick();
    check("lh_a1", ram_a, 32'h11);
    tick();
    check("lh_drain", mem_done, 0);
    tick();
    check("lh_done", mem_done, 1);
    check("lh_rdata", mem_rdata, 32'h0000FF80);
    check("lh_no_if_done", if_done, 0);
    mem_req = 1'b0;
    tick();
    check("lh_gap_idle", busy, 0);
    tick();
    check("if_after_busy", busy, 1);
    check("if_after_a0", ram_a, 32'h100);
    repeat (5) tick();
    check("if_after_done", if_done, 1);
    check("if_after_data", if_data, 32'hDEADBEEF);
    if_req = 1'b0;
    tick();
    // flush during cnt = 2
    ram[8'h40] = 8'hA1; ram[8'h41] = 8'hA2; ram[8'h42] = 8'hA3; ram[8'h43] = 8'hA4;
    if_addr = 32'h40; if_req = 1'b1;
    tick();
    tick();
    tick();
    check("fl_cnt2", ram_a, 32'h42);
    if_flush = 1'b1;
    tick();
    check("fl_idle", busy, 0);
    check("fl_no_done", if_done, 0);
    tick();
    check("fl_ignored", busy, 0);
    check("fl_data_kept", if_data, 32'hDEADBEEF);
    if_req = 1'b0; if_flush = 1'b0;
    ram[8'h50] = 8'h5A;
    mem_addr = 32'h50; mem_len = 2'b00; mem_rw = 1'b0; mem_req = 1'b1;
    tick();
    check("lb_a0", ram_a, 32'h50);
    tick();
    check("lb_drain", mem_done, 0);
    tick();
    check("lb_done", mem_done, 1);
    check("lb_rdata", mem_rdata, 32'h0000005A);
    check("lb_no_if_done", if_done, 0);
    mem_req = 1'b0;
    tick();
    // LW wrapping through address 0
    ram[8'hFE] = 8'h01; ram[8'hFF] = 8'h02; ram[8'h00] = 8'h03; ram[8'h01] = 8'h04;
    mem_addr = 32'hFFFFFFFE; mem_len = 2'b11; mem_req = 1'b1;
    tick();
    check("wrap_a0", ram_a, 32'hFFFFFFFE);
    tick();
    check("wrap_a1", ram_a, 32'hFFFFFFFF);
    tick();
    check("wrap_a2", ram_a, 32'h00000000);
    tick();
    check("wrap_a3", ram_a, 32'h00000001);
    tick();
    tick();
    check("wrap_done", mem_done, 1);
    check("wrap_rdata", mem_rdata, 32'h04030201);
    mem_req = 1'b0;
    tick();
    // reset in the middle of a SW
    mem_addr = 32'h80; mem_rw = 1'b1; mem_len = 2'b10; mem_wdata = 32'h11223344; mem_req = 1'b1;
    tick();
    tick();
    check("rs_mid_a", ram_a, 32'h81);
    check("rs_mid_wr", ram_wr, 1);
    rst = 1'b1;
    #1;
    check("rs_ram_a", ram_a, 0);
    check("rs_ram_wr", ram_wr, 0);
    check("rs_ram_dout", ram_dout, 0);
    check("rs_busy", busy, 0);
    check("rs_mem_rdata", mem_rdata, 0);
    check("rs_if_data", if_data, 0);
    tick();
    check("rs_no_done", mem_done, 0);
    rst = 1'b0;
    tick();
    check("rs_restart_a", ram_a, 32'h80);
    check("rs_restart_dout", ram_dout, 8'h44);
    check("rs_restart_wr", ram_wr, 1);
    repeat (3) tick();
    check("rs_last_dout", ram_dout, 8'h11);
    tick();
    check("rs_done", mem_done, 1);
    mem_req = 1'b0;
    tick();
    check("rs_done_drop", mem_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
